alu_seq: RTL and testbench

- Parametrised, handshaked successor to the team's 8-bit combinational ALU, for the multi-cycle CPU datapath.
- Keeps FORWARD/ADD/AND/OR with the same SELECT codes. Adds SUB, iterative multiply and iterative shifts, status flags, and valid/ready flow control.
- Operands are captured at acceptance. The result is registered and held until the consumer takes it.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_comb.sv | 47 ++++
 rtl/alu_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and sizing helper for the sequential ALU.
// Imported by alu_seq and alu_seq_comb.
package alu_seq_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence the +1.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU ops (FORWARD/ADD/AND/OR/SUB) with carry/overflow.
// Purely combinational; results are registered by the parent.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_res,
    output logic             o_carry,
    output logic             o_ovf
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_res   = '0;
        o_carry = 1'b0;
        o_ovf   = 1'b0;
        case (i_op)
            OP_FWD: o_res = i_b;
            OP_ADD: begin
                o_res   = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
                o_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_res = i_a & i_b;
            OP_OR:  o_res = i_a | i_b;
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                o_res   = w_dif[WIDTH-1:0];
                o_carry = w_dif[WIDTH];
                o_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                          (w_dif[WIDTH-1] != i_a[WIDTH-1]);
            end
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus
// iterative shift-add multiply and bit-serial shifts.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] LP_WD = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    LP_WC = CW'(WIDTH);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_oval;

    logic [WIDTH-1:0] w_cres;
    logic             w_ccar;
    logic             w_cov;
    logic             w_acc;
    logic             w_shift;
    logic [CW-1:0]    w_n;
    logic             w_imm;
    logic [WIDTH-1:0] w_imm_res;
    logic             w_imm_c;
    logic             w_imm_v;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_mlo;
    logic             w_sll;
    logic [WIDTH-1:0] w_sh_nxt;
    logic             w_sh_out;
    logic             w_last;
    logic             w_is_mul;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .i_a     (DATA1),
        .i_b     (DATA2),
        .i_op    (SELECT),
        .o_res   (w_cres),
        .o_carry (w_ccar),
        .o_ovf   (w_cov)
    );

    assign IN_READY = (r_state == ST_IDLE) ||
                      (r_state == ST_DONE && OUT_READY);
    assign w_acc    = IN_VALID && IN_READY;

    // Shift distance saturates at WIDTH; zero-distance shifts finish at once.
    assign w_shift   = SELECT[2] & SELECT[1];
    assign w_n       = (DATA2 >= LP_WD) ? LP_WC : CW'(DATA2);
    assign w_imm     = (SELECT <= OP_SUB) || (w_shift && w_n == '0);
    assign w_imm_res = w_shift ? DATA1 : w_cres;
    assign w_imm_c   = w_shift ? 1'b0 : w_ccar;
    assign w_imm_v   = w_shift ? 1'b0 : w_cov;

    // Shift-add step: {r_hi, r_b} becomes the full product after WIDTH steps.
    assign w_madd   = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mlo    = {w_madd[0], r_b[WIDTH-1:1]};
    assign w_sll    = (r_op == OP_SLL);
    assign w_sh_nxt = w_sll ? {r_a[WIDTH-2:0], 1'b0}
                            : {r_a[WIDTH-1], r_a[WIDTH-1:1]};
    assign w_sh_out = w_sll ? r_a[WIDTH-1] : r_a[0];
    assign w_last   = (r_cnt == CW'(1));
    assign w_is_mul = (r_op == OP_MUL);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_op    <= OP_FWD;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_oval  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (r_state == ST_DONE && OUT_READY) begin
                        r_state <= ST_IDLE;
                        r_oval  <= 1'b0;
                    end
                    if (w_acc) begin
                        r_op <= SELECT;
                        if (w_imm) begin
                            r_state <= ST_DONE;
                            r_oval  <= 1'b1;
                            r_res   <= w_imm_res;
                            r_zero  <= (w_imm_res == '0);
                            r_carry <= w_imm_c;
                            r_ovf   <= w_imm_v;
                        end else begin
                            r_state <= ST_BUSY;
                            r_oval  <= 1'b0;
                            r_a     <= DATA1;
                            r_b     <= DATA2;
                            r_hi    <= '0;
                            r_cnt   <= (SELECT == OP_MUL) ? LP_WC : w_n;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_is_mul) begin
                        r_hi <= w_madd[WIDTH:1];
                        r_b  <= w_mlo;
                    end else begin
                        r_a  <= w_sh_nxt;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_oval  <= 1'b1;
                        if (w_is_mul) begin
                            r_res   <= w_mlo;
                            r_zero  <= (w_mlo == '0);
                            r_carry <= 1'b0;
                            r_ovf   <= |w_madd[WIDTH:1];
                        end else begin
                            r_res   <= w_sh_nxt;
                            r_zero  <= (w_sh_nxt == '0);
                            r_carry <= w_sh_out;
                            r_ovf   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_oval  <= 1'b0;
                end
            endcase
        end
    end

    assign RESULT    = r_res;
    assign ZERO      = r_zero;
    assign CARRY     = r_carry;
    assign OVERFLOW  = r_ovf;
    assign OUT_VALID = r_oval;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases plus a
// randomized handshake mix against an arithmetic reference model.
module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] DATA1 = '0;
    logic [7:0] DATA2 = '0;
    logic [2:0] SELECT = '0;
    logic       IN_VALID = 1'b0;
    logic       OUT_READY = 1'b0;
    logic       IN_READY;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       CARRY;
    logic       OVERFLOW;
    logic       OUT_VALID;

    alu_seq #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .SELECT    (SELECT),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .RESULT    (RESULT),
        .ZERO      (ZERO),
        .CARRY     (CARRY),
        .OVERFLOW  (OVERFLOW),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
        int         lat;
        int         acc;
    } exp_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_pop = 0;
    bit   mon_en = 1'b0;
    bit   front_seen = 1'b0;
    exp_t q[$];
    exp_t fe;
    exp_t ne;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op);
        exp_t e;
        int ua, ub, sa, sb, r, n;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        n = (ub > 8) ? 8 : ub;
        r = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            3'd0: r = ub;
            3'd1: begin
                r = ua + ub;
                e.c = (r > 255);
                e.v = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: begin
                r = ua - ub;
                e.c = (ua < ub);
                e.v = (sa - sb > 127) || (sa - sb < -128);
            end
            3'd5: begin
                r = ua * ub;
                e.v = ((r >> 8) != 0);
                e.lat = 9;
            end
            3'd6: begin
                r = ua << n;
                e.c = (n > 0) ? (((ua >> (8 - n)) & 1) != 0) : 1'b0;
                e.lat = n + 1;
            end
            default: begin
                r = sa >>> n;
                e.c = (n > 0) ? (((sa >>> (n - 1)) & 1) != 0) : 1'b0;
                e.lat = n + 1;
            end
        endcase
        e.res = r[7:0];
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
        exp_t e;
        int cnt;
        int w;
        e = model(a, b, op);
        OUT_READY = 1'b0;
        w = 0;
        while (!IN_READY && w < 50) begin
            tick();
            w++;
        end
        check("rdy_wait", IN_READY, 1);
        DATA1 = a;
        DATA2 = b;
        SELECT = op;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        DATA1 = 8'($urandom);
        DATA2 = 8'($urandom);
        SELECT = 3'($urandom);
        cnt = 1;
        while (!OUT_VALID && cnt < 40) begin
            check("busy_inrdy", IN_READY, 0);
            tick();
            cnt++;
        end
        check("latency", cnt, e.lat);
        check("result", RESULT, e.res);
        check("zero", ZERO, e.z);
        check("carry", CARRY, e.c);
        check("ovf", OVERFLOW, e.v);
        check("done_inrdy", IN_READY, 0);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("handoff", OUT_VALID, 0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (OUT_VALID) begin
                check("spurious", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    fe = q[0];
                    if (!front_seen) begin
                        check("rnd_lat", cyc - fe.acc, fe.lat);
                        front_seen = 1'b1;
                    end
                    if (OUT_READY) begin
                        check("rnd_res", RESULT, fe.res);
                        check("rnd_zero", ZERO, fe.z);
                        check("rnd_carry", CARRY, fe.c);
                        check("rnd_ovf", OVERFLOW, fe.v);
                        void'(q.pop_front());
                        front_seen = 1'b0;
                        n_pop++;
                    end
                end
            end
            if (IN_VALID && IN_READY) begin
                ne = model(DATA1, DATA2, SELECT);
                ne.acc = cyc;
                q.push_back(ne);
                n_acc++;
            end
        end
    end

    initial begin
        int w;
        #1;
        check("rst_oval", OUT_VALID, 0);
        check("rst_res", RESULT, 0);
        check("rst_zero", ZERO, 0);
        check("rst_carry", CARRY, 0);
        check("rst_ovf", OVERFLOW, 0);
        tick();
        tick();
        RESET = 1'b0;
        #1;
        check("rst_inrdy", IN_READY, 1);

        run_op(8'hFF, 8'h01, 3'd1);
        run_op(8'h80, 8'h01, 3'd4);
        run_op(8'h7F, 8'h01, 3'd1);
        run_op(8'h00, 8'h01, 3'd4);
        run_op(8'h0D, 8'h0B, 3'd5);
        run_op(8'h10, 8'h10, 3'd5);
        run_op(8'h90, 8'h03, 3'd7);
        run_op(8'h81, 8'h01, 3'd6);
        run_op(8'hFF, 8'd20, 3'd6);
        run_op(8'h5A, 8'h00, 3'd6);
        run_op(8'h80, 8'h08, 3'd7);
        run_op(8'hC3, 8'h3C, 3'd2);

        // OR result held under backpressure, then same-edge handoff + AND
        DATA1 = 8'h0F;
        DATA2 = 8'hF0;
        SELECT = 3'd3;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        check("bp_oval", OUT_VALID, 1);
        for (int i = 0; i < 5; i++) begin
            DATA1 = 8'($urandom);
            tick();
            check("bp_res", RESULT, 8'hFF);
            check("bp_flags", {ZERO, CARRY, OVERFLOW}, 3'b000);
            check("bp_inrdy", IN_READY, 0);
            check("bp_hold", OUT_VALID, 1);
        end
        DATA1 = 8'h3C;
        DATA2 = 8'h0F;
        SELECT = 3'd2;
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        #1;
        check("b2b_inrdy", IN_READY, 1);
        tick();
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        check("b2b_oval", OUT_VALID, 1);
        check("b2b_res", RESULT, 8'h0C);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // Abort a multiply with reset
        DATA1 = 8'hFF;
        DATA2 = 8'hFF;
        SELECT = 3'd5;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        RESET = 1'b1;
        DATA1 = 8'h33;
        DATA2 = 8'h33;
        SELECT = 3'd0;
        IN_VALID = 1'b1;
        #1;
        check("mrst_oval", OUT_VALID, 0);
        check("mrst_res", RESULT, 0);
        check("mrst_zero", ZERO, 0);
        tick();
        tick();
        RESET = 1'b0;
        IN_VALID = 1'b0;
        #1;
        check("mrst_inrdy", IN_READY, 1);
        w = 0;
        for (int i = 0; i < 12; i++) begin
            if (OUT_VALID) w++;
            tick();
        end
        check("mrst_stale", w, 0);
        run_op(8'h11, 8'h5A, 3'd0);

        // Random handshake mix
        mon_en = 1'b1;
        w = 0;
        while (n_acc < 1000 && w < 50000) begin
            IN_VALID = ($urandom_range(0, 9) < 6);
            OUT_READY = ($urandom_range(0, 9) < 6);
            SELECT = 3'($urandom);
            DATA1 = 8'($urandom);
            DATA2 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12))
                                                : 8'($urandom);
            tick();
            w++;
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        w = 0;
        while ((q.size() != 0 || OUT_VALID) && w < 100) begin
            tick();
            w++;
        end
        mon_en = 1'b0;
        check("rnd_accepts", n_acc, 1000);
        check("rnd_drain", q.size(), 0);
        check("rnd_count", n_pop, 1000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
